// File: rtl/acc_wr_sched.sv
// Round-robin write scheduler for the shared accumulator: IDLE -> EXEC -> ACK per transaction.
// Define ACC_SAT_EN to make ADD saturate to all ones on unsigned overflow instead of wrapping.
module acc_wr_sched #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREQ  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         op,
  input  logic [NREQ*WIDTH-1:0]   data,
  input  logic [WIDTH-1:0]        acc_q,
  output logic [WIDTH-1:0]        acc_in,
  output logic                    acc_we,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic                    carry,
  output logic                    busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic              op_q, op_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              carry_q, carry_d;

  logic              found;
  logic [IW-1:0]     pick;
  int unsigned       idx;
  logic [WIDTH:0]    sum;
  logic [NREQ-1:0]   win_oh;

  // Search starts one past the last winner and wraps, so every requester is reached within NREQ grants.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, data_q};
    win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    data_d  = data_q;
    carry_d = carry_q;
    acc_in  = '0;
    acc_we  = 1'b0;
    gnt     = '0;
    ack     = '0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          op_d    = op[pick];
          data_d  = data[32'(pick)*WIDTH +: WIDTH];
          state_d = EXEC;
        end
      end
      EXEC: begin
        gnt     = win_oh;
        acc_we  = 1'b1;
        acc_in  = op_q ? sum[WIDTH-1:0] : data_q;
        carry_d = op_q & sum[WIDTH];
`ifdef ACC_SAT_EN
        if (op_q && sum[WIDTH]) acc_in = '1;
`endif
        state_d = ACK;
      end
      ACK: begin
        gnt     = win_oh;
        ack     = win_oh;
        ptr_d   = win_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign carry = carry_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      win_q   <= '0;
      op_q    <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_acc_wr_sched.sv
// Self-checking bench for acc_wr_sched: scoreboard of expected writes plus per-scenario checks.
module tb_acc_wr_sched;

  typedef struct {
    int          w;
    logic [15:0] acc;
    logic        c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  op  = '0;
  logic [47:0] data = '0;
  logic [15:0] acc_reg = 16'h0000;
  logic [15:0] acc_in;
  logic        acc_we;
  logic [2:0]  gnt, ack;
  logic        carry, busy;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          model_ptr = 2;
  logic [15:0] model_acc = 16'h0000;
  logic        preset_en = 1'b0;
  logic [15:0] preset_val = 16'h0000;
  bit          mon_en = 1'b1;
  bit          chk_pending = 1'b0;
  exp_t        cur;
  exp_t        sb[$];

  acc_wr_sched #(.WIDTH(16), .NREQ(3)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .data(data), .acc_q(acc_reg),
    .acc_in(acc_in), .acc_we(acc_we), .gnt(gnt), .ack(ack), .carry(carry), .busy(busy)
  );

  always #5 clk = ~clk;

  // External accumulator register, with a preset path for setting up operands.
  always @(posedge clk) begin
    cyc++;
    if (preset_en) acc_reg <= preset_val;
    else if (acc_we) acc_reg <= acc_in;
  end

  function automatic logic [2:0] onehot(input int w);
    onehot = 3'b001 << w;
  endfunction

  // Scoreboard consumer: pops on each write cycle, checks the ack/carry one cycle later.
  always @(negedge clk) begin
    if (chk_pending) begin
      chk_pending = 1'b0;
      n_cmp++;
      if (ack !== onehot(cur.w)) begin
        n_fail++;
        $display("FAIL sb_ack: got %b expected %b", ack, onehot(cur.w));
      end
      n_cmp++;
      if (carry !== cur.c) begin
        n_fail++;
        $display("FAIL sb_carry: got %b expected %b", carry, cur.c);
      end
    end
    if (mon_en && acc_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected_write: got acc_in %h expected no write", acc_in);
      end else begin
        cur = sb.pop_front();
        n_cmp++;
        if (gnt !== onehot(cur.w)) begin
          n_fail++;
          $display("FAIL sb_gnt: got %b expected %b", gnt, onehot(cur.w));
        end
        n_cmp++;
        if (acc_in !== cur.acc) begin
          n_fail++;
          $display("FAIL sb_acc_in: got %h expected %h", acc_in, cur.acc);
        end
        chk_pending = 1'b1;
      end
    end
  end

  task automatic issue(input logic [2:0] r, input logic [2:0] o,
                       input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    exp_t        e;
    int          w;
    logic [1:0]  wi;
    logic [1:0]  ci;
    logic [15:0] dw;
    logic [16:0] s;
    w  = -1;
    wi = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      ci = 2'((model_ptr + k) % 3);
      if (w < 0 && r[ci]) begin
        w  = int'(ci);
        wi = ci;
      end
    end
    dw = (wi == 2'd0) ? d0 : (wi == 2'd1) ? d1 : d2;
    s  = {1'b0, model_acc} + {1'b0, dw};
    e.w = w;
    if (o[wi]) begin
      e.acc = s[15:0];
      e.c   = s[16];
`ifdef ACC_SAT_EN
      if (s[16]) e.acc = 16'hFFFF;
`endif
    end else begin
      e.acc = dw;
      e.c   = 1'b0;
    end
    sb.push_back(e);
    model_acc = e.acc;
    model_ptr = w;
    req  = r;
    op   = o;
    data = {d2, d1, d0};
  endtask

  task automatic wait_ack(output int w);
    w = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack !== 3'b000) begin
        for (int j = 0; j < 3; j++) if (ack[j]) w = j;
        if (w >= 0) req[2'(w)] = 1'b0;
        break;
      end
    end
    if (w < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack expected ack within 10 cycles");
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_ptr = 2;
  endtask

  task automatic preset_acc(input logic [15:0] v);
    @(negedge clk);
    preset_en  = 1'b1;
    preset_val = v;
    @(negedge clk);
    preset_en  = 1'b0;
    model_acc  = v;
  endtask

  task automatic test_reset();
    int w;
    rst = 1'b0;
    req = 3'b111;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({gnt, ack, acc_we, carry, busy} !== 9'b0 || acc_in !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_outputs: got gnt=%b ack=%b we=%b c=%b busy=%b acc_in=%h expected all zero",
                 gnt, ack, acc_we, carry, busy, acc_in);
      end
    end
    rst = 1'b1;
    issue(3'b111, 3'b000, 16'h0C0C, 16'h1111, 16'h2222);
    wait_ack(w);
    req = '0;
    n_cmp++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL reset_first_winner: got %0d expected 0", w);
    end
  endtask

  task automatic test_single_load();
    @(negedge clk);
    issue(3'b010, 3'b000, 16'h0000, 16'h1234, 16'h0000);
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b010 || acc_we !== 1'b1 || acc_in !== 16'h1234) begin
      n_fail++;
      $display("FAIL load_exec: got gnt=%b we=%b acc_in=%h expected 010 1 1234", gnt, acc_we, acc_in);
    end
    @(negedge clk);
    n_cmp++;
    if (ack !== 3'b010 || acc_we !== 1'b0) begin
      n_fail++;
      $display("FAIL load_ack: got ack=%b we=%b expected 010 0", ack, acc_we);
    end
    req = '0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_add_overflow();
    logic [15:0] exp_acc;
`ifdef ACC_SAT_EN
    exp_acc = 16'hFFFF;
`else
    exp_acc = 16'h0010;
`endif
    preset_acc(16'hFFF0);
    issue(3'b001, 3'b001, 16'h0020, 16'h0000, 16'h0000);
    @(negedge clk);
    n_cmp++;
    if (acc_in !== exp_acc) begin
      n_fail++;
      $display("FAIL add_ovf_acc_in: got %h expected %h", acc_in, exp_acc);
    end
    @(negedge clk);
    n_cmp++;
    if (carry !== 1'b1 || ack !== 3'b001) begin
      n_fail++;
      $display("FAIL add_ovf_carry: got carry=%b ack=%b expected 1 001", carry, ack);
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int w;
    int last;
    last = 0;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      issue(3'b111, 3'($urandom_range(7)), 16'($urandom), 16'($urandom), 16'($urandom));
      wait_ack(w);
      n_cmp++;
      if (w !== k % 3) begin
        n_fail++;
        $display("FAIL rr_order_%0d: got %0d expected %0d", k, w, k % 3);
      end
      if (k > 0) begin
        n_cmp++;
        if (cyc - last !== 3) begin
          n_fail++;
          $display("FAIL rr_spacing_%0d: got %0d expected 3", k, cyc - last);
        end
      end
      last = cyc;
    end
    req = '0;
  endtask

  task automatic test_reset_midop();
    int w;
    @(negedge clk);
    mon_en = 1'b0;
    req  = 3'b100;
    op   = 3'b000;
    data = {16'hBEEF, 16'h0000, 16'h0000};
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b100 || acc_we !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_exec: got gnt=%b we=%b expected 100 1", gnt, acc_we);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 3'b000 || acc_we !== 1'b0 || ack !== 3'b000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_abort: got gnt=%b we=%b ack=%b busy=%b expected 000 0 000 0",
               gnt, acc_we, ack, busy);
    end
    preset_en  = 1'b1;
    preset_val = 16'h0100;
    @(negedge clk);
    n_cmp++;
    if (ack !== 3'b000) begin
      n_fail++;
      $display("FAIL midop_no_ack: got %b expected 000", ack);
    end
    preset_en = 1'b0;
    model_acc = 16'h0100;
    model_ptr = 2;
    rst = 1'b1;
    mon_en = 1'b1;
    issue(3'b101, 3'b001, 16'h0011, 16'h0000, 16'h7777);
    wait_ack(w);
    req = '0;
    n_cmp++;
    if (w !== 0) begin
      n_fail++;
      $display("FAIL midop_winner: got %0d expected 0", w);
    end
  endtask

  task automatic test_withdrawal();
    @(negedge clk);
    issue(3'b010, 3'b000, 16'h0000, 16'hAAAA, 16'h0000);
    @(negedge clk);
    req = 3'b000;
    data[31:16] = 16'h5555;
    #1;
    n_cmp++;
    if (acc_in !== 16'hAAAA) begin
      n_fail++;
      $display("FAIL withdraw_acc_in: got %h expected aaaa", acc_in);
    end
    @(negedge clk);
    n_cmp++;
    if (ack !== 3'b010) begin
      n_fail++;
      $display("FAIL withdraw_ack: got %b expected 010", ack);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL withdraw_idle_%0d: got busy=%b expected 0", k, busy);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_load();
    test_add_overflow();
    test_round_robin();
    test_reset_midop();
    test_withdrawal();
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0 || chk_pending) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_wr_sched.md
Name: acc_wr_sched

Overview:
- Scheduler for the shared 16-bit accumulator register.
- Arbitrates round-robin between NREQ requesters (ALU result, memory load, I/O input) that want to write the accumulator.
- Sequences each write as LOAD (acc := data) or ADD (acc := acc + data).
- Drives the accumulator's input bus and write strobe, and returns a one-cycle ack to the winning requester.

Parameters:
- WIDTH, 16, datapath width of the accumulator and requester data.
- NREQ, 3, number of requesters (2..8).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req  input  NREQ  per-requester write request, level-held until its ack.
- op  input  NREQ  per-requester operation: 0 = LOAD, 1 = ADD.
- data  input  NREQ*WIDTH  per-requester operand; requester i occupies bits [i*WIDTH +: WIDTH].
- acc_q  input  WIDTH  current accumulator value, fed back from the accumulator register.
- acc_in  output  WIDTH  next accumulator value.
- acc_we  output  1  accumulator write strobe; the accumulator captures acc_in on the edge that ends an acc_we cycle.
- gnt  output  NREQ  one-hot grant to the current winner.
- ack  output  NREQ  one-cycle completion pulse to the winner.
- carry  output  1  carry-out of the last ADD.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE -> EXEC -> ACK -> IDLE. One transaction every 3 cycles; no back-to-back overlap.
- Reset (rst=0 at a clk edge), applied from any state:
  - state = IDLE; gnt = 0; ack = 0; acc_we = 0; acc_in = 0; carry = 0; busy = 0.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
  - Any in-flight transaction is abandoned: no write, no ack.
- IDLE (cycle 0):
  - If req != 0, select the winner by round-robin: search starts at index ptr+1, wrapping modulo NREQ; the first asserted req wins.
  - On that edge, latch the winner's index, op and data, and go to EXEC.
  - If req == 0, stay in IDLE.
- EXEC (cycle 1):
  - gnt = one-hot(winner); acc_we = 1; busy = 1.
  - acc_in = latched data for LOAD; (acc_q + latched data) mod 2^WIDTH for ADD.
  - acc_in is a combinational function of acc_q and the latched operand.
  - carry is registered on the edge leaving EXEC: bit WIDTH of the sum for ADD, 0 for LOAD.
- ACK (cycle 2):
  - gnt held; ack[winner] = 1; acc_we = 0.
  - ptr := winner on the edge leaving ACK; next state IDLE.
- Requester rules:
  - A requester must drop req on the edge after it sees ack; a req still high in the following IDLE cycle is a new request.
  - data and op are sampled only at the IDLE->EXEC edge; later changes are ignored.
  - If req drops during EXEC or ACK, the transaction still completes and ack still pulses.
- Arbitration guarantees:
  - With all requesters continuously asserted, grant order is 0,1,...,NREQ-1,0,...
  - Starvation bound: NREQ transactions.
- Outputs gnt, ack, acc_we and busy are Moore (decoded from state only); none combinationally depend on req.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: ADD saturates unsigned; if the sum overflows WIDTH bits, acc_in = all ones and carry = 1. LOAD is unchanged.
- Undefined: ADD wraps modulo 2^WIDTH; carry = raw carry-out.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req=3'b111 -> gnt=0, ack=0, acc_we=0, carry=0, busy=0 throughout; first grant after release goes to requester 0.
- Single LOAD: req=3'b010, op[1]=0, data1=0x1234 -> cycle 1: gnt=3'b010, acc_we=1, acc_in=0x1234. Cycle 2: ack=3'b010. Cycle 3: busy=0.
- ADD overflow: acc_q=0xFFF0, requester 0 ADD with data0=0x0020 -> acc_in=0x0010, carry=1. With ACC_SAT_EN defined: acc_in=0xFFFF, carry=1.
- Round-robin: req=3'b111 held, each requester re-raising req after its ack -> grants in order 3'b001, 3'b010, 3'b100, 3'b001, spaced 3 cycles apart.
- Reset mid-op: rst=0 during EXEC of requester 2 -> next cycle gnt=0, acc_we=0; ack[2] never pulses; after release with req=3'b101, requester 0 wins.
- Withdrawal: requester 1 drops req during EXEC, data1 changes 0xAAAA->0x5555 -> acc_in=0xAAAA, ack[1] still pulses in cycle 2.
